// File: rtl/vend_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vend_pkg
// Description : Shared types and coin values for the parametrised vending
//               machine (vending_machine_param, vend_change_ctr).
// Revision    : 1.0 - initial release
// ============================================================================
package vend_pkg;

  // Controller state encoding
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    VEND    = 2'd2,
    CHANGE  = 2'd3
  } vend_state_t;

  // Coin values in nickel units
  localparam int NICKEL_VAL  = 1;
  localparam int DIME_VAL    = 2;
  localparam int QUARTER_VAL = 5;

  // Total value of the coins presented in one cycle (all are accepted together)
  function automatic int coin_value(input logic n, input logic d, input logic q);
    return (n ? NICKEL_VAL : 0) + (d ? DIME_VAL : 0) + (q ? QUARTER_VAL : 0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/vend_change_ctr.sv
`default_nettype none
// ============================================================================
// Module      : vend_change_ctr
// Description : Loadable down-counter that drives the change actuator. It
//               emits one change pulse per cycle while non-zero and flags the
//               last pulse with done.
// Revision    : 1.0 - initial release
// ============================================================================
module vend_change_ctr #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             change,
  output logic             done
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  // Next count: load wins, otherwise count down until empty
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - WIDTH'(1);
    end
  end

  // Count register; reset forfeits any outstanding change
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign change = (cnt_q != '0);
  assign done   = (cnt_q == WIDTH'(1));

endmodule
`default_nettype wire

// File: rtl/vending_machine_param.sv
`default_nettype none
// ============================================================================
// Module      : vending_machine_param
// Description : Multi-item vending controller with configurable price. Sums
//               nickel/dime/quarter credit, vends the latched selection and
//               returns overpayment as serial nickel pulses.
//               Optional feature macro: VEND_CANCEL_EN adds a cancel input
//               that refunds the collected credit from COLLECT.
// Revision    : 1.0 - initial release
// ============================================================================
module vending_machine_param
  import vend_pkg::*;
#(
  parameter  int PRICE    = 4,
  parameter  int N_ITEMS  = 4,
  localparam int SEL_W    = $clog2(N_ITEMS),
  localparam int CREDIT_W = $clog2(PRICE + 11)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                nickel,
  input  logic                dime,
  input  logic                quarter,
`ifdef VEND_CANCEL_EN
  input  logic                cancel,
`endif
  input  logic [SEL_W-1:0]    sel,
  output logic                dispense,
  output logic [SEL_W-1:0]    dispense_id,
  output logic                change,
  output logic                coin_reject,
  output logic                busy,
  output logic [CREDIT_W-1:0] credit
);

  localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);

  vend_state_t         state_q,       state_d;
  logic [CREDIT_W-1:0] credit_q,      credit_d;
  logic                dispense_q,    dispense_d;
  logic [SEL_W-1:0]    dispense_id_q, dispense_id_d;
  logic                busy_q,        busy_d;

  logic                any_coin;
  logic                cancel_req;
  logic                busy_state;
  logic [CREDIT_W-1:0] coin_val;
  logic [CREDIT_W-1:0] credit_sum;
  logic [CREDIT_W-1:0] credit_rem;
  logic [SEL_W-1:0]    sel_mapped;
  logic                ctr_load;
  logic [CREDIT_W-1:0] ctr_val;
  logic                ctr_done;

`ifdef VEND_CANCEL_EN
  assign cancel_req = cancel;
`else
  assign cancel_req = 1'b0;
`endif

  assign any_coin   = nickel | dime | quarter;
  assign coin_val   = CREDIT_W'(coin_value(nickel, dime, quarter));
  assign credit_sum = credit_q + coin_val;
  assign credit_rem = credit_q - PRICE_C;
  assign busy_state = (state_q == VEND) || (state_q == CHANGE);

  // Out-of-range selects fall back to item 0; a power-of-two item count
  // cannot be out of range
  generate
    if ((1 << SEL_W) == N_ITEMS) begin : g_sel_full
      assign sel_mapped = sel;
    end else begin : g_sel_clamp
      assign sel_mapped = (sel >= SEL_W'(N_ITEMS)) ? '0 : sel;
    end
  endgenerate

  // Coins are refused while busy, and also alongside a cancel request
  assign coin_reject = any_coin &
                       (busy_state | ((state_q == COLLECT) & cancel_req));

  // Next-state, credit and registered-output decode
  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    ctr_load = 1'b0;
    ctr_val  = credit_q;
    unique case (state_q)
      IDLE, COLLECT: begin
        if ((state_q == COLLECT) && cancel_req) begin
          state_d  = CHANGE;
          ctr_load = 1'b1;
          ctr_val  = credit_q;
        end else if (coin_val != '0) begin
          credit_d = credit_sum;
          state_d  = (credit_sum >= PRICE_C) ? VEND : COLLECT;
        end
      end
      VEND: begin
        credit_d = credit_rem;
        if (credit_rem != '0) begin
          state_d  = CHANGE;
          ctr_load = 1'b1;
          ctr_val  = credit_rem;
        end else begin
          state_d = IDLE;
        end
      end
      CHANGE: begin
        credit_d = credit_q - CREDIT_W'(1);
        if (ctr_done) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    dispense_d    = (state_d == VEND);
    dispense_id_d = dispense_d ? sel_mapped : '0;
    busy_d        = (state_d == VEND) || (state_d == CHANGE);
  end

  // State, credit and Moore output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      credit_q      <= '0;
      dispense_q    <= 1'b0;
      dispense_id_q <= '0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      credit_q      <= credit_d;
      dispense_q    <= dispense_d;
      dispense_id_q <= dispense_id_d;
      busy_q        <= busy_d;
    end
  end

  vend_change_ctr #(
    .WIDTH (CREDIT_W)
  ) u_change_ctr (
    .clk      (clk),
    .rst      (rst),
    .load     (ctr_load),
    .load_val (ctr_val),
    .change   (change),
    .done     (ctr_done)
  );

  assign dispense    = dispense_q;
  assign dispense_id = dispense_id_q;
  assign busy        = busy_q;
  assign credit      = credit_q;

endmodule
`default_nettype wire
